// File: rtl/axa_pkg.sv
`default_nettype none
// ============================================================================
// axa_pkg : shared FSM encoding and operand/result word ordering for the
//           2x2 matrix multiplier driver and its multiplier-side bench.
// Revision : 1.0
// ============================================================================
package axa_pkg;

  localparam int WORD_W = 32;
  localparam int N_OPS  = 8;
  localparam int N_RES  = 4;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_REQ    = 3'd1,
    ST_REL    = 3'd2,
    ST_WAIT_C = 3'd3,
    ST_ACK_C  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_ERR    = 3'd6
  } axa_state_t;

  typedef logic [2:0] op_idx_t;
  typedef logic [1:0] res_idx_t;

  // Operand load order on input_Word
  localparam op_idx_t OP_A11 = 3'd0;
  localparam op_idx_t OP_A12 = 3'd1;
  localparam op_idx_t OP_A21 = 3'd2;
  localparam op_idx_t OP_A22 = 3'd3;
  localparam op_idx_t OP_B11 = 3'd4;
  localparam op_idx_t OP_B12 = 3'd5;
  localparam op_idx_t OP_B21 = 3'd6;
  localparam op_idx_t OP_B22 = 3'd7;

  // Result presentation order on output_Result
  localparam res_idx_t RES_C11 = 2'd0;
  localparam res_idx_t RES_C12 = 2'd1;
  localparam res_idx_t RES_C21 = 2'd2;
  localparam res_idx_t RES_C22 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/axa_hs_timeout.sv
`default_nettype none
// ============================================================================
// axa_hs_timeout : loadable down-counter; expired is high once it reaches 0.
// Revision : 1.0
// ============================================================================
module axa_hs_timeout #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/axa_mult_driver.sv
`default_nettype none
// ============================================================================
// axa_mult_driver : loads 8 operand words, runs a four-phase handshake with a
//                   2x2 matrix multiplier, and streams the 4 product words out.
// Revision : 1.0
// ============================================================================
module axa_mult_driver
  import axa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              input_Clk,
  input  logic              input_Reset,
  input  logic [WORD_W-1:0] input_Word,
  input  logic              input_Word_Valid,
  output logic              output_Word_Ready,
  output logic [WORD_W-1:0] output_A11,
  output logic [WORD_W-1:0] output_A12,
  output logic [WORD_W-1:0] output_A21,
  output logic [WORD_W-1:0] output_A22,
  output logic [WORD_W-1:0] output_B11,
  output logic [WORD_W-1:0] output_B12,
  output logic [WORD_W-1:0] output_B21,
  output logic [WORD_W-1:0] output_B22,
  output logic              output_Stable,
  input  logic              input_AB_Ack,
  input  logic [WORD_W-1:0] input_C11,
  input  logic [WORD_W-1:0] input_C12,
  input  logic [WORD_W-1:0] input_C21,
  input  logic [WORD_W-1:0] input_C22,
  input  logic              input_Stable,
  output logic              output_C_Ack,
  output logic [WORD_W-1:0] output_Result,
  output logic              output_Result_Valid,
  input  logic              input_Result_Ready,
  output logic              output_Busy,
  output logic              output_Error
);

  localparam int                TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  axa_state_t        state_q;
  axa_state_t        state_d;
  logic [WORD_W-1:0] op_q  [N_OPS];
  logic [WORD_W-1:0] op_d  [N_OPS];
  logic [WORD_W-1:0] res_q [N_RES];
  logic [WORD_W-1:0] res_d [N_RES];
  op_idx_t           op_idx_q;
  op_idx_t           op_idx_d;
  res_idx_t          res_idx_q;
  res_idx_t          res_idx_d;
  logic              stable_q;
  logic              stable_d;
  logic              tmr_load;
  logic              tmr_expired;

  // Shared wait counter: reloaded on every state change, so each handshake
  // state gets a fresh TIMEOUT_CYCLES window from the cycle it is entered.
  axa_hs_timeout #(
    .WIDTH (TMR_W)
  ) u_timeout (
    .clk        (input_Clk),
    .rst        (input_Reset),
    .load       (tmr_load),
    .load_value (TMR_RELOAD),
    .expired    (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    op_idx_d  = op_idx_q;
    res_idx_d = res_idx_q;
    stable_d  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (input_Word_Valid) begin
          op_d[op_idx_q] = input_Word;
          op_idx_d       = op_idx_q + 3'd1;
          if (op_idx_q == OP_B22) begin
            state_d  = ST_REQ;
            stable_d = ~input_AB_Ack;
          end
        end
      end

      // Stable is only raised on an edge where Ack was seen low.
      ST_REQ: begin
        if (stable_q && input_AB_Ack) begin
          state_d = ST_REL;
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end else begin
          stable_d = stable_q | ~input_AB_Ack;
        end
      end

      ST_REL: begin
        if (!input_AB_Ack) begin
          state_d = ST_WAIT_C;
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_WAIT_C: begin
        if (input_Stable) begin
          res_d[RES_C11] = input_C11;
          res_d[RES_C12] = input_C12;
          res_d[RES_C21] = input_C21;
          res_d[RES_C22] = input_C22;
          state_d        = ST_ACK_C;
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_ACK_C: begin
        if (!input_Stable) begin
          state_d = ST_DRAIN;
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_DRAIN: begin
        if (input_Result_Ready) begin
          res_idx_d = res_idx_q + 2'd1;
          if (res_idx_q == RES_C22) begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase

    tmr_load = (state_d != state_q);
  end

  always_ff @(posedge input_Clk) begin
    if (input_Reset) begin
      state_q   <= ST_LOAD;
      op_idx_q  <= '0;
      res_idx_q <= '0;
      stable_q  <= 1'b0;
      for (int i = 0; i < N_OPS; i++) begin
        op_q[i] <= '0;
      end
      for (int i = 0; i < N_RES; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      op_idx_q  <= op_idx_d;
      res_idx_q <= res_idx_d;
      stable_q  <= stable_d;
      op_q      <= op_d;
      res_q     <= res_d;
    end
  end

  assign output_Word_Ready   = (state_q == ST_LOAD);
  assign output_Stable       = stable_q;
  assign output_C_Ack        = (state_q == ST_ACK_C);
  assign output_Result_Valid = (state_q == ST_DRAIN);
  assign output_Result       = res_q[res_idx_q];
  assign output_Busy         = (state_q != ST_LOAD);
  assign output_Error        = (state_q == ST_ERR);

  assign output_A11 = op_q[OP_A11];
  assign output_A12 = op_q[OP_A12];
  assign output_A21 = op_q[OP_A21];
  assign output_A22 = op_q[OP_A22];
  assign output_B11 = op_q[OP_B11];
  assign output_B12 = op_q[OP_B12];
  assign output_B21 = op_q[OP_B21];
  assign output_B22 = op_q[OP_B22];

endmodule
`default_nettype wire

// File: tb/tb_axa_mult_driver.sv
`default_nettype none
// ============================================================================
// tb_axa_mult_driver : scoreboard bench with a behavioural 2x2 multiplier.
// Revision : 1.0
// ============================================================================
module tb_axa_mult_driver;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic        o_stable;
  logic        ab_ack;
  logic [31:0] c11, c12, c21, c22;
  logic        i_stable;
  logic        c_ack;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        error;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_ops[8];
  logic [31:0] dut_ops[8];
  bit          pat_all[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit          pat_tog[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  assign dut_ops[0] = a11;
  assign dut_ops[1] = a12;
  assign dut_ops[2] = a21;
  assign dut_ops[3] = a22;
  assign dut_ops[4] = b11;
  assign dut_ops[5] = b12;
  assign dut_ops[6] = b21;
  assign dut_ops[7] = b22;

  axa_mult_driver #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .input_Clk           (clk),
    .input_Reset         (rst),
    .input_Word          (word),
    .input_Word_Valid    (word_valid),
    .output_Word_Ready   (word_ready),
    .output_A11          (a11),
    .output_A12          (a12),
    .output_A21          (a21),
    .output_A22          (a22),
    .output_B11          (b11),
    .output_B12          (b12),
    .output_B21          (b21),
    .output_B22          (b22),
    .output_Stable       (o_stable),
    .input_AB_Ack        (ab_ack),
    .input_C11           (c11),
    .input_C12           (c12),
    .input_C21           (c21),
    .input_C22           (c22),
    .input_Stable        (i_stable),
    .output_C_Ack        (c_ack),
    .output_Result       (result),
    .output_Result_Valid (result_valid),
    .input_Result_Ready  (result_ready),
    .output_Busy         (busy),
    .output_Error        (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference 2x2 product, modulo 2^32, operands in load order
  function automatic void matmul(input logic [31:0] w[8], output logic [31:0] c[4]);
    c[0] = w[0] * w[4] + w[1] * w[6];
    c[1] = w[0] * w[5] + w[1] * w[7];
    c[2] = w[2] * w[4] + w[3] * w[6];
    c[3] = w[2] * w[5] + w[3] * w[7];
  endfunction

  task automatic load_txn(input logic [31:0] w[8], input logic [31:0] c[4]);
    int guard;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[i]);
    for (int i = 0; i < 8; i++) cur_ops[i] = w[i];
    for (int i = 0; i < 8; i++) begin
      word       = w[i];
      word_valid = 1'b1;
      guard      = 0;
      while (!word_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!word_ready) chk("load_ready", 32'(word_ready), 1);
      @(posedge clk);
      #1;
    end
    word_valid = 1'b0;
    word       = 32'hDEAD_BEEF;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_word_ready"}, 32'(word_ready), 1);
    chk({tag, "_stable"}, 32'(o_stable), 0);
    chk({tag, "_c_ack"}, 32'(c_ack), 0);
    chk({tag, "_rvalid"}, 32'(result_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_result"}, result, 0);
    for (int i = 0; i < 8; i++) chk({tag, "_operand"}, dut_ops[i], 0);
  endtask

  // Multiplier side: called at a negedge while the driver is requesting.
  task automatic mult_side(input int ack_delay, input bit rst_in_ack);
    int          guard;
    logic [31:0] c[4];
    guard = 0;
    while (!o_stable && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("stable_up", 32'(o_stable), 1);
    for (int i = 0; i < 8; i++) chk("operand", dut_ops[i], cur_ops[i]);
    for (int k = 0; k < ack_delay; k++) begin
      @(negedge clk);
      chk("stable_hold", 32'(o_stable), 1);
      chk("hold_error", 32'(error), 0);
      for (int i = 0; i < 8; i++) chk("operand_hold", dut_ops[i], cur_ops[i]);
    end
    matmul(dut_ops, c);
    @(posedge clk);
    #1 ab_ack = 1'b1;
    guard = 0;
    while (o_stable && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("stable_drop", 32'(o_stable), 0);
    ab_ack = 1'b0;
    repeat (2) @(negedge clk);
    c11 = c[0]; c12 = c[1]; c21 = c[2]; c22 = c[3];
    i_stable = 1'b1;
    chk("c_ack_early", 32'(c_ack), 0);
    @(negedge clk);
    chk("c_ack_latency", 32'(c_ack), 1);
    if (rst_in_ack) begin
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("rst_ack");
      rst      = 1'b0;
      i_stable = 1'b0;
      exp_q.delete();
    end else begin
      i_stable = 1'b0;
      c11 = ~c[0]; c12 = ~c[1]; c21 = ~c[2]; c22 = ~c[3];
      @(negedge clk);
      chk("c_ack_drop", 32'(c_ack), 0);
    end
  endtask

  task automatic drain(input bit pat[4]);
    int          got;
    int          guard;
    int          k;
    bit          held;
    logic [31:0] held_w;
    logic [31:0] e;
    got = 0; guard = 0; k = 0; held = 1'b0; held_w = '0;
    while (got < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (result_valid) begin
        if (held) chk("result_hold", result, held_w);
        result_ready = pat[k % 4];
        k++;
        if (result_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
          chk("result", result, e);
          got++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_w = result;
        end
      end else begin
        result_ready = 1'b0;
      end
    end
    if (got < 4) chk("drain_count", got, 4);
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(busy), 0);
    chk("rvalid_after", 32'(result_valid), 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[8];
    logic [31:0] c[4];
    int          n;

    rst = 1'b1; word = '0; word_valid = 1'b0; ab_ack = 1'b0;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0; i_stable = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // A=[1,2;3,4], B=[5,6;7,8]
    w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    c = '{32'd19, 32'd22, 32'd43, 32'd50};
    load_txn(w, c);
    @(negedge clk);
    chk("stable_latency", 32'(o_stable), 1);
    chk("busy_req", 32'(busy), 1);
    chk("word_ready_busy", 32'(word_ready), 0);
    word = 32'h5A5A_5A5A;
    word_valid = 1'b1;
    mult_side(0, 1'b0);
    word_valid = 1'b0;
    drain(pat_all);

    // Delayed AB_Ack with a stalling result consumer
    w = '{32'd10, 32'hFFFF_0000, 32'd3, 32'h1234_5678, 32'd9, 32'd11, 32'd13, 32'h7FFF_FFFF};
    matmul(w, c);
    load_txn(w, c);
    mult_side(7, 1'b0);
    drain(pat_tog);
    chk("no_error_delay", 32'(error), 0);

    // Back-to-back extreme values
    w = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    matmul(w, c);
    load_txn(w, c);
    mult_side(1, 1'b0);
    drain(pat_all);
    w = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF};
    matmul(w, c);
    load_txn(w, c);
    mult_side(2, 1'b0);
    drain(pat_tog);

    // Reset while C_Ack is high
    w = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    matmul(w, c);
    load_txn(w, c);
    mult_side(0, 1'b1);

    // Recovery after that reset
    w = '{32'd2, 32'd0, 32'd0, 32'd2, 32'd9, 32'd8, 32'd7, 32'd6};
    matmul(w, c);
    load_txn(w, c);
    mult_side(3, 1'b0);
    drain(pat_all);

    // AB_Ack never arrives
    w = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    matmul(w, c);
    load_txn(w, c);
    exp_q.delete();
    @(negedge clk);
    chk("tmo_stable_up", 32'(o_stable), 1);
    n = 0;
    while (!error && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TO);
    chk("tmo_error", 32'(error), 1);
    chk("tmo_stable", 32'(o_stable), 0);
    chk("tmo_word_ready", 32'(word_ready), 0);
    chk("tmo_c_ack", 32'(c_ack), 0);
    chk("tmo_rvalid", 32'(result_valid), 0);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", 32'(error), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_err");
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axa_mult_driver.md
AXA_MULT_DRIVER -- requirements
Module: axa_mult_driver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles spent waiting on any single multiplier handshake edge before error.
REQ-002 input_Clk  in  1  sole clock; all logic on rising edge.
REQ-003 input_Reset  in  1  synchronous, active-high reset.
REQ-004 input_Word  in  32  operand word; load order A11,A12,A21,A22,B11,B12,B21,B22.
REQ-005 input_Word_Valid  in  1  input_Word valid this cycle.
REQ-006 output_Word_Ready  out  1  driver accepts an operand word this cycle.
REQ-007 output_A11..output_A22, output_B11..output_B22  out  32 each  operands presented to the multiplier.
REQ-008 output_Stable  out  1  operands valid (request to multiplier).
REQ-009 input_AB_Ack  in  1  multiplier has captured operands.
REQ-010 input_C11..input_C22  in  32 each  product from the multiplier.
REQ-011 input_Stable  in  1  product valid from the multiplier.
REQ-012 output_C_Ack  out  1  product captured by driver.
REQ-013 output_Result  out  32  result word; order C11,C12,C21,C22.
REQ-014 output_Result_Valid  out  1  output_Result valid.
REQ-015 input_Result_Ready  in  1  downstream accepts result word.
REQ-016 output_Busy  out  1  high in every state except LOAD.
REQ-017 output_Error  out  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be LOAD, REQ, REL, WAIT_C, ACK_C, DRAIN, ERR; reset state LOAD.
REQ-019 LOAD: output_Word_Ready=1; a word is taken when Valid&&Ready; a 3-bit index selects the operand register; after the 8th word go to REQ next cycle.
REQ-020 REQ: output_Stable=1, operand registers held constant; on input_AB_Ack=1 go to REL.
REQ-021 REL: output_Stable=0; on input_AB_Ack=0 go to WAIT_C.
REQ-022 WAIT_C: on input_Stable=1 capture input_C11..C22 into result registers that same edge, go to ACK_C.
REQ-023 ACK_C: output_C_Ack=1; on input_Stable=0 deassert output_C_Ack and go to DRAIN.
REQ-024 DRAIN: present 4 result words in order; the index advances only on Valid&&Ready; Result/Valid held while Ready=0; after the 4th transfer return to LOAD.
REQ-025 Four-phase rule: output_Stable never rises while input_AB_Ack=1; output_C_Ack never rises unless input_Stable=1.
REQ-026 Each of REQ, REL, WAIT_C, ACK_C has a wait counter, cleared on state entry; reaching TIMEOUT_CYCLES without the expected edge SHALL go to ERR.
REQ-027 ERR: output_Error=1, all handshake and valid outputs 0, Word_Ready=0; exits only by reset.
REQ-028 Data SHALL pass through unmodified, bit-exact, with no arithmetic.
REQ-029 Minimum end-to-end latency: 1 cycle from the 8th word accepted to output_Stable=1; 1 cycle from input_Stable=1 to output_C_Ack=1.
REQ-030 Input_Word_Valid in any state other than LOAD SHALL be ignored (Ready=0).

Reset
REQ-031 Reset in any state, including mid-handshake or mid-drain, SHALL give next cycle: state LOAD, Word_Ready=1, output_Stable=0, output_C_Ack=0, Result_Valid=0, Busy=0, Error=0, indices and counters 0, all data registers 0.

Structure
REQ-032 State encodings and the operand and result order indices SHALL be defined in a shared package axa_pkg, reused by the multiplier bench.
REQ-033 One sub-module, axa_hs_timeout (loadable down-counter with expiry flag), SHALL be instantiated once.

Verification
REQ-034 Load A=[1,2;3,4], B=[5,6;7,8] as 32-bit ints, multiplier model returns C=[19,22;43,50] -> Result stream 19,22,43,50, Busy low afterwards.
REQ-035 Multiplier model delays AB_Ack by 7 cycles -> output_Stable held 7+ cycles with operands constant, no error.
REQ-036 input_Result_Ready toggles 1,0,0,1 -> each result word held stable while Ready=0, no word skipped or duplicated.
REQ-037 TIMEOUT_CYCLES=16, model never raises AB_Ack -> output_Error=1 exactly 16 cycles after REQ entry, output_Stable=0.
REQ-038 Assert reset during ACK_C with output_C_Ack=1 -> next cycle output_C_Ack=0, Word_Ready=1, Error=0.
REQ-039 Back-to-back transactions with words 0xFFFFFFFF and 0x80000000 -> bit-exact pass-through, with a single idle cycle permitted between DRAIN and LOAD.
